reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 32: cycles all reset outputs are held after any reset event (>=1).
REQ-002 SHALL have parameter CHANNELS, default 2: number of staged reset outputs (1..16).
REQ-003 SHALL have parameter STAGGER, default 4: cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter WDT_CYCLES, default 1024: watchdog timeout in cycles (>=2).
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high block reset.
REQ-007 SHALL have port sw_req  input  1  software reset request, sampled each cycle.
REQ-008 SHALL have port wdt_en  input  1  watchdog enable.
REQ-009 SHALL have port wdt_kick  input  1  watchdog restart strobe.
REQ-010 SHALL have port rst_out  output  CHANNELS  active-high reset per domain; bit 0 released first.
REQ-011 SHALL have port ready  output  1  high only when all rst_out bits are low.
REQ-012 SHALL have port cause  output  2  last reset cause: 00 power/reset, 01 software, 10 watchdog.
REQ-013 SHALL have port boot_count  output  8  saturating count of software and watchdog resets.

Function
REQ-014 SHALL implement states HOLD, STAGE, RUN; all outputs registered.
REQ-015 HOLD: hold counter increments each cycle; on the edge where it equals HOLD_CYCLES-1, SHALL enter STAGE and clear rst_out[0] on that same edge.
REQ-016 STAGE: SHALL clear rst_out[k] exactly k*STAGGER cycles after rst_out[0] cleared, one bit at a time, in ascending order.
REQ-017 ready SHALL rise on the same edge rst_out[CHANNELS-1] clears, and the FSM SHALL enter RUN on that edge.
REQ-018 Timing: with reset last sampled high at edge E0, rst_out[k] SHALL fall at E0+HOLD_CYCLES+k*STAGGER.
REQ-019 CHANNELS=1: ready SHALL rise with rst_out[0] at E0+HOLD_CYCLES.
REQ-020 Watchdog counter SHALL increment only in RUN with wdt_en=1; held at 0 when wdt_en=0 or outside RUN.
REQ-021 wdt_kick=1 in RUN SHALL clear the watchdog counter to 0 on the next edge.
REQ-022 Expiry: counter == WDT_CYCLES-1 with wdt_kick=0, in RUN with wdt_en=1.
REQ-023 In RUN, sw_req=1 or expiry SHALL, on the next edge: set rst_out all ones, clear ready, enter HOLD with hold counter 0, clear watchdog counter, and increment boot_count.
REQ-024 cause SHALL be set to 01 for sw_req and 10 for expiry; if both occur in the same cycle, sw_req wins (cause=01) and boot_count increments once.
REQ-025 wdt_kick coincident with the expiry condition SHALL prevent expiry.
REQ-026 sw_req, wdt_kick and wdt_en SHALL be ignored in HOLD and STAGE.
REQ-027 boot_count SHALL saturate at 255 and never wrap.
REQ-028 Internal counters SHALL be sized by $clog2 of their limits and SHALL never wrap.

Reset
REQ-029 reset=1 SHALL on the next edge force: state HOLD, hold/stagger/watchdog counters 0, rst_out all ones, ready 0, cause 00, boot_count 0.
REQ-030 reset asserted in any state, including mid-STAGE or RUN, SHALL produce REQ-029 values and restart the full sequence from HOLD.

Verification
REQ-031 Power-on, defaults: reset high 3 cycles then low -> rst_out=11 through edge E0+31, 10 at E0+32, 00 with ready=1 at E0+36; cause=00; boot_count=0.
REQ-032 One-cycle sw_req in RUN -> next edge: rst_out=11, ready=0, cause=01, boot_count=1; rst_out[0] falls 32 cycles later, ready rises 36 cycles later.
REQ-033 wdt_en=1, no kicks -> reset fires 1024 edges after ready rose; cause=10, boot_count increments; kick every 1000 cycles -> no reset over 10000 cycles.
REQ-034 Kick coincident with expiry -> no reset; sw_req coincident with expiry -> cause=01, boot_count +1 only.
REQ-035 sw_req during HOLD and during STAGE -> no effect on timing, cause or boot_count; reset asserted mid-STAGE -> rst_out=11, ready=0, sequence restarts.
REQ-036 300 sw_req events -> boot_count=255; CHANNELS=4, STAGGER=2 -> rst_out[3:0] release at E0+32, 34, 36, 38, with ready rising at E0+38.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release with software reset and watchdog.
//
// After any reset event all rst_out bits are held high for HOLD_CYCLES cycles.
// Bit 0 is then released, and each further bit follows STAGGER cycles after the
// previous one. When the last bit drops, ready rises and the block enters RUN.
// In RUN, a software request or a watchdog expiry restarts the whole sequence
// and is recorded in cause and boot_count.
//
// Ports:
//   CLK        in   sole clock, rising edge
//   reset      in   synchronous active-high block reset
//   sw_req     in   software reset request (honoured in RUN only)
//   wdt_en     in   watchdog enable (RUN only)
//   wdt_kick   in   watchdog restart strobe (RUN only)
//   rst_out    out  per-domain active-high reset, bit 0 released first
//   ready      out  high only when every rst_out bit is low
//   cause      out  last reset cause: 00 reset, 01 software, 10 watchdog
//   boot_count out  saturating count of software and watchdog resets
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 32,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned STAGGER     = 4,
    parameter int unsigned WDT_CYCLES  = 1024
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                sw_req,
    input  logic                wdt_en,
    input  logic                wdt_kick,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready,
    output logic [1:0]          cause,
    output logic [7:0]          boot_count
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned StgW  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned WdtW  = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [StgW-1:0]  StgLast  = StgW'(STAGGER - 1);
    localparam logic [WdtW-1:0]  WdtLast  = WdtW'(WDT_CYCLES - 1);

    localparam logic [1:0] CauseReset = 2'b00;
    localparam logic [1:0] CauseSw    = 2'b01;
    localparam logic [1:0] CauseWdt   = 2'b10;

    typedef enum logic [1:0] {StHold, StStage, StRun} state_e;

    state_e              state_q, state_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [StgW-1:0]     stg_q, stg_d;
    logic [WdtW-1:0]     wdt_q, wdt_d;
    logic [CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                ready_q, ready_d;
    logic [1:0]          cause_q, cause_d;
    logic [7:0]          boot_q, boot_d;

    // Released bits are always the low ones, so a left shift drops the next
    // channel in ascending order without tracking a channel index.
    logic [CHANNELS-1:0] rst_shift;
    logic                expire;

    assign rst_shift = rst_out_q << 1;
    assign expire    = wdt_en && !wdt_kick && (wdt_q == WdtLast);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stg_d     = stg_q;
        wdt_d     = wdt_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        cause_d   = cause_q;
        boot_d    = boot_q;

        unique case (state_q)
            StHold: begin
                if (hold_q == HoldLast) begin
                    hold_d    = '0;
                    stg_d     = '0;
                    rst_out_d = rst_shift;
                    // Single-channel builds go straight to RUN.
                    if (rst_shift == '0) begin
                        ready_d = 1'b1;
                        state_d = StRun;
                    end else begin
                        state_d = StStage;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StStage: begin
                if (stg_q == StgLast) begin
                    stg_d     = '0;
                    rst_out_d = rst_shift;
                    if (rst_shift == '0) begin
                        ready_d = 1'b1;
                        state_d = StRun;
                    end
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            StRun: begin
                if (sw_req || expire) begin
                    state_d   = StHold;
                    hold_d    = '0;
                    stg_d     = '0;
                    wdt_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    // Software request takes priority over a coincident expiry.
                    cause_d   = sw_req ? CauseSw : CauseWdt;
                    if (boot_q != 8'hFF) begin
                        boot_d = boot_q + 8'd1;
                    end
                end else if (!wdt_en || wdt_kick) begin
                    wdt_d = '0;
                end else begin
                    // Not expired, so wdt_q < WdtLast here and cannot wrap.
                    wdt_d = wdt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StHold;
                hold_d    = '0;
                rst_out_d = '1;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StHold;
            hold_q    <= '0;
            stg_q     <= '0;
            wdt_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= CauseReset;
            boot_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stg_q     <= stg_d;
            wdt_q     <= wdt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            cause_q   <= cause_d;
            boot_q    <= boot_d;
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign cause      = cause_q;
    assign boot_count = boot_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default build plus a 4-channel/stagger-2
// build and a single-channel/hold-5 build sharing the block reset.
module tb_reset_sequencer;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic sw_req = 1'b0;
    logic wdt_en = 1'b0;
    logic wdt_kick = 1'b0;
    logic idle = 1'b0;

    logic [1:0] rst_out0;
    logic       ready0;
    logic [1:0] cause0;
    logic [7:0] boot0;

    logic [3:0] rst_out1;
    logic       ready1;
    logic [1:0] cause1;
    logic [7:0] boot1;

    logic [0:0] rst_out2;
    logic       ready2;
    logic [1:0] cause2;
    logic [7:0] boot2;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    reset_sequencer dut0 (
        .CLK        (CLK),
        .reset      (reset),
        .sw_req     (sw_req),
        .wdt_en     (wdt_en),
        .wdt_kick   (wdt_kick),
        .rst_out    (rst_out0),
        .ready      (ready0),
        .cause      (cause0),
        .boot_count (boot0)
    );

    reset_sequencer #(.CHANNELS(4), .STAGGER(2)) dut1 (
        .CLK        (CLK),
        .reset      (reset),
        .sw_req     (idle),
        .wdt_en     (idle),
        .wdt_kick   (idle),
        .rst_out    (rst_out1),
        .ready      (ready1),
        .cause      (cause1),
        .boot_count (boot1)
    );

    reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(5)) dut2 (
        .CLK        (CLK),
        .reset      (reset),
        .sw_req     (idle),
        .wdt_en     (idle),
        .wdt_kick   (idle),
        .rst_out    (rst_out2),
        .ready      (ready2),
        .cause      (cause2),
        .boot_count (boot2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Power-on: reset high for 3 edges, the last being E0.
        tick(3);
        reset = 1'b0;
        chk("por_rst0", 32'(rst_out0), 32'h3);
        chk("por_ready0", 32'(ready0), 32'h0);
        chk("por_cause0", 32'(cause0), 32'h0);
        chk("por_boot0", 32'(boot0), 32'h0);
        chk("por_rst1", 32'(rst_out1), 32'hF);

        tick(4);  // E0+4
        chk("c1_hold_rst", 32'(rst_out2), 32'h1);
        chk("c1_hold_ready", 32'(ready2), 32'h0);
        tick(1);  // E0+5
        chk("c1_rel_rst", 32'(rst_out2), 32'h0);
        chk("c1_rel_ready", 32'(ready2), 32'h1);

        tick(26); // E0+31
        chk("e31_rst0", 32'(rst_out0), 32'h3);
        chk("e31_rst1", 32'(rst_out1), 32'hF);
        tick(1);  // E0+32
        chk("e32_rst0", 32'(rst_out0), 32'h2);
        chk("e32_rst1", 32'(rst_out1), 32'hE);
        tick(2);  // E0+34
        chk("e34_rst1", 32'(rst_out1), 32'hC);
        chk("e34_ready0", 32'(ready0), 32'h0);
        tick(2);  // E0+36
        chk("e36_rst0", 32'(rst_out0), 32'h0);
        chk("e36_ready0", 32'(ready0), 32'h1);
        chk("e36_rst1", 32'(rst_out1), 32'h8);
        chk("e36_ready1", 32'(ready1), 32'h0);
        tick(2);  // E0+38
        chk("e38_rst1", 32'(rst_out1), 32'h0);
        chk("e38_ready1", 32'(ready1), 32'h1);

        // One-cycle software reset in RUN (edge S).
        sw_req = 1'b1;
        tick(1);
        chk("sw_rst", 32'(rst_out0), 32'h3);
        chk("sw_ready", 32'(ready0), 32'h0);
        chk("sw_cause", 32'(cause0), 32'h1);
        chk("sw_boot", 32'(boot0), 32'h1);
        // sw_req held through S+1 lands in HOLD and must be ignored.
        tick(1);
        sw_req = 1'b0;
        chk("hold_sw_boot", 32'(boot0), 32'h1);
        tick(30); // S+31
        chk("s31_rst", 32'(rst_out0), 32'h3);
        tick(1);  // S+32
        chk("s32_rst", 32'(rst_out0), 32'h2);
        sw_req = 1'b1; // in STAGE, ignored
        tick(1);
        sw_req = 1'b0;
        tick(2);  // S+35
        chk("s35_rst", 32'(rst_out0), 32'h2);
        chk("s35_ready", 32'(ready0), 32'h0);
        chk("stage_sw_boot", 32'(boot0), 32'h1);
        chk("stage_sw_cause", 32'(cause0), 32'h1);
        tick(1);  // S+36 = R
        chk("s36_ready", 32'(ready0), 32'h1);

        // Watchdog expiry 1024 edges after ready rose.
        wdt_en = 1'b1;
        tick(1023);
        chk("wdt_pre_ready", 32'(ready0), 32'h1);
        tick(1);
        chk("wdt_rst", 32'(rst_out0), 32'h3);
        chk("wdt_cause", 32'(cause0), 32'h2);
        chk("wdt_boot", 32'(boot0), 32'h2);
        tick(36);
        chk("wdt_rerun_ready", 32'(ready0), 32'h1);

        // Kick every 1000 cycles: no reset over 10000 cycles.
        for (int i = 0; i < 10; i++) begin
            tick(999);
            wdt_kick = 1'b1;
            tick(1);
            wdt_kick = 1'b0;
            chk("kick_ready", 32'(ready0), 32'h1);
        end
        chk("kick_boot", 32'(boot0), 32'h2);

        // Kick coincident with expiry prevents it.
        tick(1023);
        wdt_kick = 1'b1;
        tick(1);
        wdt_kick = 1'b0;
        chk("kick_exp_ready", 32'(ready0), 32'h1);
        chk("kick_exp_boot", 32'(boot0), 32'h2);

        // sw_req coincident with expiry: software cause, single increment.
        tick(1023);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        wdt_en = 1'b0;
        chk("both_rst", 32'(rst_out0), 32'h3);
        chk("both_cause", 32'(cause0), 32'h1);
        chk("both_boot", 32'(boot0), 32'h3);

        // Reset asserted mid-STAGE.
        tick(33);
        chk("mid_stage_rst", 32'(rst_out0), 32'h2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_rst", 32'(rst_out0), 32'h3);
        chk("mid_rst_ready", 32'(ready0), 32'h0);
        chk("mid_rst_cause", 32'(cause0), 32'h0);
        chk("mid_rst_boot", 32'(boot0), 32'h0);
        tick(31);
        chk("restart_e31", 32'(rst_out0), 32'h3);
        tick(1);
        chk("restart_e32", 32'(rst_out0), 32'h2);
        tick(4);
        chk("restart_ready", 32'(ready0), 32'h1);

        // 300 software resets saturate boot_count at 255.
        for (int i = 0; i < 300; i++) begin
            sw_req = 1'b1;
            tick(1);
            sw_req = 1'b0;
            tick(36);
        end
        chk("sat_boot", 32'(boot0), 32'hFF);
        chk("sat_cause", 32'(cause0), 32'h1);
        chk("sat_ready", 32'(ready0), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
